// File: rtl/id_track_ctrl_if.sv
// Request/response handshake bundle between a monitored AXI request channel
// (AW or AR), its response channel (B or R-last) and the ID tracking table.
interface id_track_ctrl_if #(
    parameter int unsigned IdWidth = 4
);

    logic               req_valid_i;
    logic               req_ready_o;
    logic [IdWidth-1:0] req_id_i;
    logic               rsp_valid_i;
    logic [IdWidth-1:0] rsp_id_i;

    // Monitor side: presents observed requests/responses, sees table readiness
    modport master (
        output req_valid_i,
        output req_id_i,
        output rsp_valid_i,
        output rsp_id_i,
        input  req_ready_o
    );

    // Table side
    modport slave (
        input  req_valid_i,
        input  req_id_i,
        input  rsp_valid_i,
        input  rsp_id_i,
        output req_ready_o
    );

endinterface

// File: rtl/id_track_ctrl.sv
// Per-ID head/tail tracking table for the AXI monitor.
// Each entry tracks one outstanding ID: FREE -> ACTIVE -> EXPIRED, with an
// outstanding-transaction counter and a response-budget timer. Allocation and
// readiness are decided from registered table state only, so an entry freed
// by a response cannot be reused until the following cycle.
module id_track_ctrl #(
    parameter  int unsigned NumIds  = 4,
    parameter  int unsigned IdWidth = 4,
    parameter  int unsigned MaxTxns = 8,
    parameter  int unsigned Budget  = 16,
    localparam int unsigned IdxW    = (NumIds > 1) ? $clog2(NumIds) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    id_track_ctrl_if.slave     bus,
    input  logic               clr_i,
    output logic               timeout_o,
    output logic [IdxW-1:0]    timeout_idx_o,
    output logic [IdWidth-1:0] timeout_id_o,
    output logic               rsp_err_o,
    output logic               full_o
);

    localparam int unsigned CntW = $clog2(MaxTxns + 1);
    localparam int unsigned TmrW = $clog2(Budget + 1);

    localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(Budget);
    localparam logic [TmrW-1:0] TmrOne = TmrW'(1);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_EXPIRED = 2'd2
    } entry_state_e;

    // Table state
    entry_state_e       state_q [NumIds];
    entry_state_e       state_d [NumIds];
    logic [IdWidth-1:0] id_q    [NumIds];
    logic [IdWidth-1:0] id_d    [NumIds];
    logic [CntW-1:0]    cnt_q   [NumIds];
    logic [CntW-1:0]    cnt_d   [NumIds];
    logic [TmrW-1:0]    timer_q [NumIds];
    logic [TmrW-1:0]    timer_d [NumIds];

    // Registered reporting
    logic               timeout_q,     timeout_d;
    logic [IdxW-1:0]    timeout_idx_q, timeout_idx_d;
    logic [IdWidth-1:0] timeout_id_q,  timeout_id_d;
    logic               rsp_err_q,     rsp_err_d;

    // Lookup results
    logic [NumIds-1:0]  free_vec;
    logic [NumIds-1:0]  req_match;
    logic [NumIds-1:0]  rsp_match;
    logic [NumIds-1:0]  acc_sel;
    logic               free_any;
    logic [IdxW-1:0]    free_idx;
    logic               req_hit;
    logic [IdxW-1:0]    req_hit_idx;
    logic               rsp_hit;
    logic               req_ready;
    logic               accept;

    // ID match vectors against the registered table
    always_comb begin
        free_vec  = '0;
        req_match = '0;
        rsp_match = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            free_vec[i]  = (state_q[i] == ST_FREE);
            req_match[i] = !free_vec[i] && (id_q[i] == bus.req_id_i);
            rsp_match[i] = !free_vec[i] && (id_q[i] == bus.rsp_id_i);
        end
    end

    // Lowest FREE slot, matching slot, readiness and per-entry accept select
    always_comb begin
        free_any    = 1'b0;
        free_idx    = '0;
        req_hit_idx = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            if (free_vec[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = IdxW'(i);
            end
            if (req_match[i]) begin
                req_hit_idx = IdxW'(i);
            end
        end
        req_hit   = |req_match;
        rsp_hit   = |rsp_match;
        req_ready = req_hit ? (cnt_q[req_hit_idx] < CntMax) : free_any;
        accept    = bus.req_valid_i && req_ready;
        acc_sel   = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            acc_sel[i] = accept && (req_hit ? req_match[i] : (IdxW'(i) == free_idx));
        end
    end

    // Per-entry next state: response beats accept, clear beats timer aging
    always_comb begin
        for (int unsigned i = 0; i < NumIds; i++) begin
            state_d[i] = state_q[i];
            id_d[i]    = id_q[i];
            cnt_d[i]   = cnt_q[i];
            timer_d[i] = timer_q[i];

            if (acc_sel[i] && bus.rsp_valid_i && rsp_match[i]) begin
                // Request and response cancel; the entry is never freed here
                state_d[i] = ST_ACTIVE;
                timer_d[i] = '0;
            end else if (bus.rsp_valid_i && rsp_match[i]) begin
                cnt_d[i]   = cnt_q[i] - CntOne;
                timer_d[i] = '0;
                if (cnt_d[i] == '0) begin
                    state_d[i] = ST_FREE;
                    id_d[i]    = '0;
                end else begin
                    state_d[i] = ST_ACTIVE;
                end
            end else if (state_q[i] == ST_FREE) begin
                if (acc_sel[i]) begin
                    state_d[i] = ST_ACTIVE;
                    id_d[i]    = bus.req_id_i;
                    cnt_d[i]   = CntOne;
                    timer_d[i] = '0;
                end
            end else begin
                if (acc_sel[i]) begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
                if (state_q[i] == ST_EXPIRED) begin
                    if (clr_i) begin
                        state_d[i] = ST_ACTIVE;
                        timer_d[i] = '0;
                    end
                end else begin
                    timer_d[i] = (timer_q[i] == TmrMax) ? TmrMax : timer_q[i] + TmrOne;
                    if (timer_d[i] == TmrMax) begin
                        state_d[i] = ST_EXPIRED;
                    end
                end
            end
        end
    end

    // Timeout report from next state (lowest EXPIRED entry) and error pulse
    always_comb begin
        timeout_d     = 1'b0;
        timeout_idx_d = '0;
        timeout_id_d  = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            if ((state_d[i] == ST_EXPIRED) && !timeout_d) begin
                timeout_d     = 1'b1;
                timeout_idx_d = IdxW'(i);
                timeout_id_d  = id_d[i];
            end
        end
        rsp_err_d = bus.rsp_valid_i && !rsp_hit;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                state_q[i] <= ST_FREE;
                id_q[i]    <= '0;
                cnt_q[i]   <= '0;
                timer_q[i] <= '0;
            end
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
            timeout_id_q  <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                state_q[i] <= state_d[i];
                id_q[i]    <= id_d[i];
                cnt_q[i]   <= cnt_d[i];
                timer_q[i] <= timer_d[i];
            end
            timeout_q     <= timeout_d;
            timeout_idx_q <= timeout_idx_d;
            timeout_id_q  <= timeout_id_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign full_o          = !free_any;
    assign timeout_o       = timeout_q;
    assign timeout_idx_o   = timeout_idx_q;
    assign timeout_id_o    = timeout_id_q;
    assign rsp_err_o       = rsp_err_q;

endmodule
